// File: rtl/man_pkg.sv
// Shared definitions for the 16-bit Manchester link: defaults, decoder
// state type and the gap-window thresholds used to classify line edges.
package man_pkg;

  localparam int unsigned HALF_BIT_CYCLES_DEF = 36;
  localparam int unsigned DATA_W_DEF          = 16;

  typedef enum logic {
    IDLE,
    DATA
  } man_state_t;

  // Edges closer than this to the last mid-bit edge are glitches.
  function automatic int unsigned win_glitch(input int unsigned h);
    return h / 2;
  endfunction

  // Start of the mid-bit window; below it (and above the glitch limit) an
  // edge is a bit-boundary edge.
  function automatic int unsigned win_mid_lo(input int unsigned h);
    return (3 * h) / 2;
  endfunction

  // Last gap value still accepted as a mid-bit edge.
  function automatic int unsigned win_mid_hi(input int unsigned h);
    return (5 * h) / 2;
  endfunction

endpackage

// File: rtl/man_edge_sync.sv
// Two-flop synchroniser for the asynchronous Manchester line, followed by a
// registered copy of the synced level so rising/falling edges can be seen.
module man_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_din,
  output logic o_rise,
  output logic o_fall,
  output logic o_level
);

  logic r_s1;
  logic r_s2;
  logic r_lvl;

  // Synchronise the line and keep the previous synced level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_lvl <= 1'b0;
    end else begin
      r_s1  <= i_din;
      r_s2  <= r_s1;
      r_lvl <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_lvl;
  assign o_fall  = ~r_s2 & r_lvl;

endmodule

// File: rtl/man_decoding_slave.sv
// Manchester frame decoder: arms after a quiet low line, takes the first
// rising edge as the start bit's mid-edge, then classifies each edge by its
// distance from the previous mid-bit edge to recover DATA_W bits.
module man_decoding_slave
  import man_pkg::*;
#(
  parameter int unsigned HALF_BIT_CYCLES = HALF_BIT_CYCLES_DEF,
  parameter int unsigned DATA_W          = DATA_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              man_code,
  output logic [0:DATA_W-1] rx_data,
  output logic              rx_flag,
  output logic              rx_err,
  output logic              busy
);

  localparam int unsigned GAP_MAX = win_mid_hi(HALF_BIT_CYCLES) + 1;
  localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(DATA_W + 1);

  localparam logic [GAP_W-1:0] C_GLITCH = GAP_W'(win_glitch(HALF_BIT_CYCLES));
  localparam logic [GAP_W-1:0] C_MID_LO = GAP_W'(win_mid_lo(HALF_BIT_CYCLES));
  localparam logic [GAP_W-1:0] C_TMO    = GAP_W'(GAP_MAX);
  localparam logic [GAP_W-1:0] C_ARM    = GAP_W'(HALF_BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] C_LAST   = BIT_W'(DATA_W - 1);

  logic w_rise;
  logic w_fall;
  logic w_level;
  logic w_abort;

  man_state_t        r_state, w_state_nxt;
  logic [GAP_W-1:0]  r_gap,   w_gap_nxt;
  logic [BIT_W-1:0]  r_bits,  w_bits_nxt;
  logic              r_bnd,   w_bnd_nxt;
  logic              r_armed, w_armed_nxt;
  logic [0:DATA_W-1] r_shift, w_shift_nxt;
  logic [0:DATA_W-1] r_data,  w_data_nxt;
  logic              r_flag,  w_flag_nxt;
  logic              r_err,   w_err_nxt;
  logic              r_busy,  w_busy_nxt;

  man_edge_sync u_sync (
    .i_clk   (clk_in),
    .i_rst   (rst),
    .i_din   (man_code),
    .o_rise  (w_rise),
    .o_fall  (w_fall),
    .o_level (w_level)
  );

  // State, counters, shift register and output strobes.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state <= IDLE;
      r_gap   <= '0;
      r_bits  <= '0;
      r_bnd   <= 1'b0;
      r_armed <= 1'b0;
      r_shift <= '0;
      r_data  <= '0;
      r_flag  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
      r_bits  <= w_bits_nxt;
      r_bnd   <= w_bnd_nxt;
      r_armed <= w_armed_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_flag  <= w_flag_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state decode; in IDLE the gap counter doubles as the low-line counter.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_bits_nxt  = r_bits;
    w_bnd_nxt   = r_bnd;
    w_armed_nxt = r_armed;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_flag_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_busy_nxt  = r_busy;
    w_abort     = 1'b0;

    case (r_state)
      IDLE: begin
        if (!r_armed) begin
          if (w_level) begin
            w_gap_nxt = '0;
          end else if (r_gap == C_ARM) begin
            w_armed_nxt = 1'b1;
            w_gap_nxt   = '0;
          end else begin
            w_gap_nxt = r_gap + 1'b1;
          end
        end else if (w_rise) begin
          w_state_nxt = DATA;
          w_gap_nxt   = '0;
          w_bits_nxt  = '0;
          w_bnd_nxt   = 1'b0;
          w_armed_nxt = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      DATA: begin
        if (r_gap == C_TMO) begin
          w_abort = 1'b1;
        end else if (w_rise || w_fall) begin
          if (r_gap < C_GLITCH) begin
            w_abort = 1'b1;
          end else if (r_gap < C_MID_LO) begin
            if (r_bnd) begin
              w_abort = 1'b1;
            end else begin
              w_bnd_nxt = 1'b1;
              w_gap_nxt = r_gap + 1'b1;
            end
          end else begin
            w_shift_nxt = {r_shift[1:DATA_W-1], w_rise};
            w_gap_nxt   = '0;
            w_bnd_nxt   = 1'b0;
            w_bits_nxt  = r_bits + 1'b1;
            if (r_bits == C_LAST) begin
              w_data_nxt  = w_shift_nxt;
              w_flag_nxt  = 1'b1;
              w_busy_nxt  = 1'b0;
              w_state_nxt = IDLE;
            end
          end
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_abort) begin
      w_err_nxt   = 1'b1;
      w_busy_nxt  = 1'b0;
      w_state_nxt = IDLE;
      w_armed_nxt = 1'b0;
      w_gap_nxt   = '0;
    end
  end

  assign rx_data = r_data;
  assign rx_flag = r_flag;
  assign rx_err  = r_err;
  assign busy    = r_busy;

endmodule

// File: tb/tb_man_decoding_slave.sv
// Directed + randomised bench for the Manchester decoder. A behavioural
// line encoder drives frames; expectations come from the frame contents.
module tb_man_decoding_slave;

  localparam int H  = 36;
  localparam int DW = 16;

  logic          clk_in   = 1'b0;
  logic          rst      = 1'b1;
  logic          man_code = 1'b0;
  logic [0:DW-1] rx_data;
  logic          rx_flag;
  logic          rx_err;
  logic          busy;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  man_decoding_slave #(.HALF_BIT_CYCLES(H), .DATA_W(DW)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .man_code (man_code),
    .rx_data  (rx_data),
    .rx_flag  (rx_flag),
    .rx_err   (rx_err),
    .busy     (busy)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Strobe monitor: counts pulses, records their cycle and checks exclusivity.
  int            n_flag = 0, n_err = 0, n_busy = 0, n_viol = 0;
  int            flag_cyc = -1, err_cyc = -1;
  logic          prev_flag = 1'b0, prev_err = 1'b0;
  always @(negedge clk_in) begin
    if (rx_flag === 1'b1) begin n_flag++; flag_cyc = cyc; end
    if (rx_err === 1'b1) begin n_err++; err_cyc = cyc; end
    if (busy === 1'b1) n_busy++;
    if ((rx_flag === 1'b1 && rx_err === 1'b1) ||
        (rx_flag === 1'b1 && prev_flag === 1'b1) ||
        (rx_err === 1'b1 && prev_err === 1'b1)) n_viol++;
    prev_flag = rx_flag;
    prev_err  = rx_err;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int last_mid_cyc = 0;
  int glitch_cyc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic lvl);
    @(negedge clk_in);
    man_code = lvl;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0);
  endtask

  task automatic settle();
    @(posedge clk_in);
    #1;
  endtask

  // Encode start bit + first nbits of w (index 0 first). Each mid-bit gap is
  // 2H +/- jit cycles. glitch_k / rst_k pick a bit to corrupt (-1 = none).
  task automatic send_frame(input logic [0:DW-1] w, input int nbits, input int jit,
                            input int glitch_k, input int rst_k);
    int   m [0:DW];
    logic b [0:DW];
    int   t, e, d;
    b[0] = 1'b1;
    m[0] = H;
    for (int k = 1; k <= DW; k++) begin
      b[k] = w[k-1];
      d    = (jit > 0) ? int'($urandom_range(2 * jit)) - jit : 0;
      m[k] = m[k-1] + 2 * H + d;
    end
    t = 0;
    for (int k = 0; k <= nbits; k++) begin
      while (t < m[k]) begin drive(~b[k]); t++; end
      drive(b[k]);
      last_mid_cyc = cyc;
      t++;
      if (k == glitch_k) begin
        repeat (9) drive(b[k]);
        drive(~b[k]);
        glitch_cyc = cyc;
        repeat (4) drive(~b[k]);
        drive(1'b0);
        return;
      end
      if (k == rst_k) begin
        repeat (H / 2) drive(b[k]);
        @(negedge clk_in);
        rst      = 1'b1;
        man_code = 1'b0;
        settle();
        check("rst_mid_data", 32'(rx_data), 32'd0);
        check("rst_mid_flag", 32'(rx_flag), 32'd0);
        check("rst_mid_err",  32'(rx_err),  32'd0);
        check("rst_mid_busy", 32'(busy),    32'd0);
        @(negedge clk_in);
        rst = 1'b0;
        return;
      end
      e = (k == nbits) ? m[k] + H : (m[k] + m[k+1]) / 2;
      while (t < e) begin drive(b[k]); t++; end
    end
    drive(1'b0);
  endtask

  initial begin
    int            f0, e0, b0;
    logic [0:DW-1] exp_data, wd;
    exp_data = '0;

    // Reset state
    repeat (3) @(negedge clk_in);
    settle();
    check("reset_data", 32'(rx_data), 32'(exp_data));
    check("reset_flag", 32'(rx_flag), 32'd0);
    check("reset_err",  32'(rx_err),  32'd0);
    check("reset_busy", 32'(busy),    32'd0);
    @(negedge clk_in);
    rst = 1'b0;
    idle(2 * H);

    // Nominal frame
    f0 = n_flag; e0 = n_err; b0 = n_busy;
    send_frame(16'hA5C3, DW, 0, -1, -1);
    exp_data = 16'hA5C3;
    idle(4); settle();
    check("nom_flags",   32'(n_flag - f0), 32'd1);
    check("nom_data",    32'(rx_data), 32'(exp_data));
    check("nom_err",     32'(n_err - e0), 32'd0);
    check("nom_latency", 32'(flag_cyc), 32'(last_mid_cyc + 3));
    check("nom_busy_len", 32'((n_busy - b0 >= 32 * H - 3) && (n_busy - b0 <= 32 * H + 3)), 32'd1);

    // Extreme patterns with 2H idle between
    idle(2 * H);
    f0 = n_flag; e0 = n_err;
    send_frame(16'h0000, DW, 0, -1, -1);
    settle();
    check("zero_data", 32'(rx_data), 32'h0000);
    idle(2 * H);
    send_frame(16'hFFFF, DW, 0, -1, -1);
    exp_data = 16'hFFFF;
    settle();
    check("ones_data",  32'(rx_data), 32'(exp_data));
    check("ext_flags",  32'(n_flag - f0), 32'd2);
    idle(4 * H); settle();
    check("ones_tail_flags", 32'(n_flag - f0), 32'd2);
    check("ones_tail_err",   32'(n_err - e0), 32'd0);
    check("ones_tail_busy",  32'(busy), 32'd0);

    // Jittered frames: fixed 0x1234 then random words
    for (int i = 0; i < 4; i++) begin
      idle(2 * H);
      wd = (i == 0) ? 16'h1234 : DW'($urandom);
      f0 = n_flag;
      send_frame(wd, DW, H / 2 - 2, -1, -1);
      exp_data = wd;
      settle();
      check("jit_data",  32'(rx_data), 32'(exp_data));
      check("jit_flags", 32'(n_flag - f0), 32'd1);
    end

    // Truncated frame: timeout error, data held
    idle(2 * H);
    f0 = n_flag; e0 = n_err;
    send_frame(DW'($urandom), 8, 0, -1, -1);
    for (int i = 0; i < 300 && n_err == e0; i++) settle();
    settle();
    check("trunc_err",   32'(n_err - e0), 32'd1);
    check("trunc_flags", 32'(n_flag - f0), 32'd0);
    check("trunc_hold",  32'(rx_data), 32'(exp_data));
    check("trunc_latency", 32'((err_cyc >= last_mid_cyc + 94) && (err_cyc <= last_mid_cyc + 96)), 32'd1);

    // Glitch 10 cycles after a mid-bit edge, then a clean frame
    idle(2 * H);
    f0 = n_flag; e0 = n_err;
    send_frame(DW'($urandom), DW, 0, 3, -1);
    for (int i = 0; i < 100 && n_err == e0; i++) settle();
    check("glitch_err",     32'(n_err - e0), 32'd1);
    check("glitch_flags",   32'(n_flag - f0), 32'd0);
    check("glitch_hold",    32'(rx_data), 32'(exp_data));
    check("glitch_latency", 32'(err_cyc), 32'(glitch_cyc + 3));
    idle(2 * H);
    f0 = n_flag;
    send_frame(16'h00FF, DW, 0, -1, -1);
    exp_data = 16'h00FF;
    settle();
    check("post_glitch_data",  32'(rx_data), 32'(exp_data));
    check("post_glitch_flags", 32'(n_flag - f0), 32'd1);

    // Reset during bit 6, then a fresh frame
    idle(2 * H);
    f0 = n_flag; e0 = n_err;
    send_frame(DW'($urandom), DW, 0, -1, 6);
    exp_data = '0;
    idle(200); settle();
    check("rst_no_flag", 32'(n_flag - f0), 32'd0);
    check("rst_no_err",  32'(n_err - e0),  32'd0);
    wd = DW'($urandom);
    f0 = n_flag;
    send_frame(wd, DW, 0, -1, -1);
    exp_data = wd;
    settle();
    check("post_rst_data",  32'(rx_data), 32'(exp_data));
    check("post_rst_flags", 32'(n_flag - f0), 32'd1);

    idle(4);
    settle();
    check("strobe_exclusive", 32'(n_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
